// File: rtl/demux4_stream_if.sv
// demux4_stream_if -- stream bundle for the 4-way demux.
//   Input side : in_valid, in_data[WIDTH], in_sel[2]  (producer -> demux)
//                in_ready                              (demux -> producer)
//   Output side: out_valid[4], out_data[4*WIDTH]       (demux -> consumers)
//                out_ready[4]                          (consumers -> demux)
// Channel k's head word sits at out_data[k*WIDTH +: WIDTH].
// Modports: master = producer/consumer side (testbench), slave = demux.
interface demux4_stream_if #(
    parameter int WIDTH = 13
);
    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic [1:0]           in_sel;
    logic                 in_ready;
    logic [3:0]           out_valid;
    logic [4*WIDTH-1:0]   out_data;
    logic [3:0]           out_ready;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux4_stream.sv
// demux4_stream -- routes one input stream to four output channels, each
// buffered by a 2-entry FIFO.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, clears all queues
//   bus      : demux4_stream_if.slave (input stream + 4 output streams)
//   xfer_cnt : 8-bit saturating count of accepted input words
//              (port exists only when DEMUX4_STATS_EN is defined)
// Optional feature macro: DEMUX4_STATS_EN.

// Per-channel 2-entry FIFO.
//   push/push_data : write request (ignored when full)
//   pop_rdy        : consumer ready; pops only while valid
//   valid/data     : head word; data holds the last popped word while empty
//   full           : occupancy == 2
module demux4_stream_chan #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_rdy,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             full
);
    logic [1:0][WIDTH-1:0] mem;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic [WIDTH-1:0]      last_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign valid   = (count != 2'd0);
    assign full    = (count == 2'd2);
    assign push_ok = push & ~full;
    assign pop_ok  = pop_rdy & valid;

    // When empty, keep presenting the word that left last rather than
    // whatever stale entry rd_ptr now points at.
    assign data = valid ? mem[rd_ptr] : last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            last_q <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
                last_q <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

module demux4_stream #(
    parameter int WIDTH = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    demux4_stream_if.slave    bus
`ifdef DEMUX4_STATS_EN
    ,
    output logic [7:0]        xfer_cnt
`endif
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0]            lane_full;
    logic [NUM_LANES-1:0]            lane_push;
    logic [NUM_LANES-1:0]            lane_valid;
    logic [NUM_LANES-1:0][WIDTH-1:0] lane_data;
    logic                            in_xfer;

    // Ready looks only at the selected channel's occupancy, never at
    // out_ready, so there is no combinational path consumer -> producer.
    assign bus.in_ready = ~lane_full[bus.in_sel];
    assign in_xfer      = bus.in_valid & bus.in_ready;

    assign bus.out_valid = lane_valid;
    assign bus.out_data  = lane_data;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane_push[k] = in_xfer & (bus.in_sel == 2'(k));

        demux4_stream_chan #(.WIDTH(WIDTH)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (lane_push[k]),
            .push_data (bus.in_data),
            .pop_rdy   (bus.out_ready[k]),
            .valid     (lane_valid[k]),
            .data      (lane_data[k]),
            .full      (lane_full[k])
        );
    end

`ifdef DEMUX4_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            xfer_cnt <= 8'd0;
        else if (in_xfer && (xfer_cnt != 8'hFF))
            xfer_cnt <= xfer_cnt + 8'd1;
    end
`endif
endmodule

// File: doc/demux4_stream.md
DEMUX4_STREAM -- requirements
Module: demux4_stream

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 13, payload width in bits.
REQ-002 Clocking and reset SHALL be one clock and an asynchronous, active-low reset.
REQ-003 Port clk SHALL be: clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst_n SHALL be: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port in_valid SHALL be: in_valid  input  1  upstream word present.
REQ-006 Port in_data SHALL be: in_data  input  WIDTH  upstream payload.
REQ-007 Port in_sel SHALL be: in_sel  input  2  destination channel 0..3, qualified by in_valid.
REQ-008 Port in_ready SHALL be: in_ready  output  1  selected channel can accept.
REQ-009 Port out_valid SHALL be: out_valid  output  4  bit k = channel k head word valid.
REQ-010 Port out_data SHALL be: out_data  output  4*WIDTH  channel k head word at bits [k*WIDTH +: WIDTH].
REQ-011 Port out_ready SHALL be: out_ready  input  4  bit k = channel k consumer accepts.
REQ-012 Port xfer_cnt SHALL be: xfer_cnt  output  8  saturating accepted-word count; present only with DEMUX4_STATS_EN.

Function
REQ-013 Each channel SHALL hold a 2-entry FIFO with occupancy count 0..2; out_valid[k] = (count_k != 0).
REQ-014 in_ready SHALL be combinational: 1 iff count of channel in_sel < 2; it SHALL NOT depend on out_ready.
REQ-015 An input transfer SHALL occur when in_valid && in_ready; the word is pushed into channel in_sel only.
REQ-016 An output transfer on channel k SHALL occur when out_valid[k] && out_ready[k]; the head entry is popped.
REQ-017 Latency SHALL be one cycle: a word accepted at edge N appears on out_data of an empty channel after edge N.
REQ-018 Each channel SHALL preserve FIFO order; words from different channels are independent.
REQ-019 Simultaneous push and pop on one channel SHALL leave count unchanged (count 1 -> 1, new word queued behind head); with count 2 no push occurs.
REQ-020 Pop on an empty channel SHALL have no effect; out_ready with out_valid=0 is ignored.
REQ-021 out_data for a channel with count 0 SHALL hold its last value (0 after reset) and is don't-care to consumers.
REQ-022 Pointers SHALL wrap modulo 2; no entry is ever overwritten or dropped.
REQ-023 When in_valid=0, in_sel and in_data SHALL be ignored and no state changes from the input side.

Reset
REQ-024 rst_n low SHALL asynchronously clear all counts, pointers, storage, out_valid (4'b0000), out_data (0) and xfer_cnt (0).
REQ-025 Reset mid-operation SHALL discard all queued words; after release in_ready = 1 for every in_sel.

Configuration
REQ-026 With macro DEMUX4_STATS_EN defined, xfer_cnt SHALL increment by 1 per input transfer and saturate at 255.
REQ-027 Without DEMUX4_STATS_EN, port xfer_cnt and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Reset, then push 13'h0AB to sel 2 -> next cycle out_valid=4'b0100, channel 2 data 13'h0AB.
REQ-029 Push 3 words to sel 1 with out_ready=0 -> first two accepted, in_ready=0 on third; out_ready[1]=1 then yields them in order.
REQ-030 Channel 0 count 1, push and pop same cycle -> count stays 1, head becomes the new word.
REQ-031 Interleave sel 0,3,0,3 with all out_ready=1 -> each channel outputs its own words in order, none lost.
REQ-032 Assert rst_n=0 with channels full -> out_valid=0 immediately, in_ready=1 after release.
REQ-033 With DEMUX4_STATS_EN, 300 accepted words -> xfer_cnt = 255; without macro, build passes with no xfer_cnt port.
